// File: rtl/drops_pkg.sv
// drops_pkg: shared sizes, reset constants, row type and LFSR step for the drops game.
package drops_pkg;
  localparam int ROWS = 8;
  localparam int COLS = 8;
  localparam logic [7:0] LFSR_SEED = 8'hA5;
  // x^8+x^6+x^5+x^4+1 on a left-shifting register: taps at bits 7,5,4,3
  localparam logic [7:0] LFSR_TAPS = 8'hB8;
  localparam logic [2:0] PADDLE_RESET = 3'd3;
  typedef logic [COLS-1:0] row_t;
  function automatic logic [7:0] lfsr_next(input logic [7:0] s);
    return {s[6:0], ^(s & LFSR_TAPS)};
  endfunction
endpackage

// File: rtl/drops_btn_edge.sv
// drops_btn_edge: 2-FF synchronizer with a one-cycle rising-edge pulse.
//   clk, rst_n : clock, asynchronous active-low reset
//   din        : raw asynchronous button level
//   pulse      : high for one cycle after a synchronized rising edge
module drops_btn_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic pulse
);
  logic [2:0] sr;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) sr <= '0;
    else sr <= {sr[1:0], din};
  assign pulse = sr[1] & ~sr[2];
endmodule

// File: rtl/drops_game.sv
// drops_game: catch-the-falling-drops game driving an 8x8 row-multiplexed LED matrix.
//   clk, rst_n : clock, asynchronous active-low reset
//   ena        : tile select, ignored
//   ui_in      : [0] move right, [1] move left, [2] show score, [7:3] unused
//   uio_in     : unused
//   uo_out     : column data of the scanned row (or the score), active high
//   uio_out    : one-hot row select
//   uio_oe     : constant 8'hFF
// Optional: define DROPS_SPEEDUP_EN to shorten the step period as the score grows.
module drops_game #(
  parameter int DROP_PERIOD = 4096,
  parameter int SCAN_DIV    = 16,
  parameter int MAX_MISSES  = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);
  import drops_pkg::*;
  localparam int TW = $clog2(DROP_PERIOD + 1);
  localparam int SW = SCAN_DIV > 1 ? $clog2(SCAN_DIV) : 1;
  localparam logic [TW-1:0] PERIOD_MAX = TW'(DROP_PERIOD);
  localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);
  localparam logic [3:0] MISS_LIMIT = 4'(MAX_MISSES);
  row_t [ROWS-2:0] field;
  row_t [ROWS-1:0] frame;
  row_t last, pmask;
  logic [TW-1:0] tick, period, period_nxt;
  logic [SW-1:0] scan;
  logic [7:0] score, score_nxt, lfsr;
  logic [3:0] misses, misses_nxt;
  logic [2:0] paddle, row;
  logic game_over, step_cnt, wrap, step, right, left;
  logic unused;
  assign unused = &{1'b0, ena, uio_in, ui_in[7:3]};
  drops_btn_edge u_right (.clk(clk), .rst_n(rst_n), .din(ui_in[0]), .pulse(right));
  drops_btn_edge u_left  (.clk(clk), .rst_n(rst_n), .din(ui_in[1]), .pulse(left));
`ifdef DROPS_SPEEDUP_EN
  logic [1:0] shift;
  // min(score[7:3], 3): any of bits 7:5 set already means >= 4
  assign shift = |score[7:5] ? 2'd3 : score[4:3];
  assign period_nxt = PERIOD_MAX >> shift;
`else
  assign period_nxt = PERIOD_MAX;
`endif
  assign wrap = tick == period - 1'b1;
  assign step = wrap & ~game_over;
  assign last = field[ROWS-2];
  assign pmask = row_t'(1) << paddle;
  assign score_nxt = (|(last & pmask) && score != 8'hFF) ? score + 1'b1 : score;
  assign misses_nxt = misses + 4'($countones(last & ~pmask));
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      field <= '0;
      paddle <= PADDLE_RESET;
      score <= '0;
      misses <= '0;
      game_over <= 1'b0;
      lfsr <= LFSR_SEED;
      step_cnt <= 1'b0;
      tick <= '0;
      period <= PERIOD_MAX;
      scan <= '0;
      row <= '0;
    end else begin
      lfsr <= lfsr_next(lfsr);
      tick <= wrap ? '0 : tick + 1'b1;
      if (wrap) period <= period_nxt;
      if (step) begin
        field <= {field[ROWS-3:0], step_cnt ? row_t'(0) : row_t'(1) << lfsr[2:0]};
        step_cnt <= ~step_cnt;
        score <= score_nxt;
        misses <= misses_nxt;
        if (misses_nxt >= MISS_LIMIT) game_over <= 1'b1;
      end
      // simultaneous edges cancel; the ends of the row clamp
      if (!game_over && right != left)
        paddle <= right ? (paddle == 3'd7 ? paddle : paddle + 1'b1)
                        : (paddle == 3'd0 ? paddle : paddle - 1'b1);
      scan <= scan == SCAN_LAST ? '0 : scan + 1'b1;
      if (scan == SCAN_LAST) row <= row + 1'b1;
    end
  assign frame = {game_over ? row_t'(8'hFF) : pmask, field};
  assign uo_out = ui_in[2] ? score : frame[row];
  assign uio_out = 8'(1) << row;
  assign uio_oe = 8'hFF;
endmodule

// File: tb/tb_drops_game.sv
// tb_drops_game: scoreboard bench for drops_game with a short step period and fast scan.
module tb_drops_game;
  localparam int DP = 128;
  localparam int SD = 4;
  logic clk = 1'b0, rst_n = 1'b0, ena = 1'b1;
  logic [7:0] ui_in = '0, uio_in = '0, uo_out, uio_out, uio_oe;
  int errors = 0, checks = 0, cyc;
  string tag_q[$];
  logic [7:0] exp_q[$];
  always #5 clk = ~clk;
  drops_game #(.DROP_PERIOD(DP), .SCAN_DIV(SD), .MAX_MISSES(3)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .ui_in(ui_in), .uio_in(uio_in),
    .uo_out(uo_out), .uio_out(uio_out), .uio_oe(uio_oe)
  );
  always @(posedge clk or negedge rst_n)
    if (!rst_n) cyc <= 0;
    else cyc <= cyc + 1;
  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %02h expected %02h", tag, got, exp);
    end
  endtask
  function automatic logic [7:0] lfsr_at(input int n);
    logic [7:0] l = 8'hA5;
    for (int i = 0; i < n; i++) l = {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
    return l;
  endfunction
  // column spawned by step k (k even), latched on clock edge (k+1)*DP
  function automatic int col(input int k);
    logic [7:0] l;
    l = lfsr_at((k + 1) * DP - 1);
    return int'(l[2:0]);
  endfunction
  task automatic push(input string tag, input logic [7:0] v);
    tag_q.push_back(tag);
    exp_q.push_back(v);
  endtask
  task automatic observe(input int r);
    int n = 0;
    logic [7:0] sel;
    sel = 8'(1) << r;
    while (uio_out !== sel && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) check("row_timeout", uio_out, sel);
    if (exp_q.size() != 0) check(tag_q.pop_front(), uo_out, exp_q.pop_front());
  endtask
  task automatic do_reset();
    @(posedge clk);
    #2 rst_n = 1'b0;
    ui_in = '0;
    #15 rst_n = 1'b1;
    #1;
  endtask
  task automatic press(input int b);
    ui_in[b] = 1'b1;
    repeat (4) @(negedge clk);
    ui_in[b] = 1'b0;
    repeat (4) @(negedge clk);
  endtask
  task automatic move(input int from, input int to);
    for (int i = from; i < to; i++) press(0);
    for (int i = from; i > to; i--) press(1);
  endtask
  task automatic wait_cyc(input int n);
    while (cyc < n) @(negedge clk);
  endtask
  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
  initial begin
    int p, c0, c1, c2, c10;
    do_reset();
    check("oe", uio_oe, 8'hFF);
    check("rst_sel", uio_out, 8'h01);
    push("rst_row0", 8'h00);
    observe(0);
    push("rst_row7", 8'h08);
    observe(7);
    do_reset();
    for (int i = 0; i < 4; i++) begin
      press(i % 2 == 0 ? 1 : 0);
      push("alt_move", i % 2 == 0 ? 8'h04 : 8'h08);
      observe(7);
    end
    ui_in[0] = 1'b1;
    repeat (40) @(negedge clk);
    ui_in[0] = 1'b0;
    repeat (4) @(negedge clk);
    push("held_once", 8'h10);
    observe(7);
    ui_in[1:0] = 2'b11;
    repeat (4) @(negedge clk);
    ui_in[1:0] = 2'b00;
    repeat (4) @(negedge clk);
    push("both_none", 8'h10);
    observe(7);
    do_reset();
    p = 3;
    for (int i = 0; i < 5; i++) begin
      press(0);
      p = p == 7 ? 7 : p + 1;
      push("right_clamp", 8'(1) << p);
      observe(7);
    end
    for (int i = 0; i < 7; i++) begin
      press(1);
      p = p == 0 ? 0 : p - 1;
      push("left_clamp", 8'(1) << p);
      observe(7);
    end
    do_reset();
    c0 = col(0);
    c1 = col(2);
    move(3, c0);
    wait_cyc(DP + 8);
    push("spawn_row0", 8'(1) << c0);
    observe(0);
    wait_cyc(4 * DP + 8);
    push("spawn2_row1", 8'(1) << c1);
    observe(1);
    push("gap_row2", 8'h00);
    observe(2);
    push("fall_row3", 8'(1) << c0);
    observe(3);
    wait_cyc(7 * DP + 8);
    push("fall_row6", 8'(1) << c0);
    observe(6);
    push("paddle_c0", 8'(1) << c0);
    observe(7);
    wait_cyc(8 * DP + 8);
    ui_in[2] = 1'b1;
    push("score1", 8'h01);
    observe(5);
    ui_in[2] = 1'b0;
    move(c0, c1);
    wait_cyc(10 * DP + 8);
    ui_in[2] = 1'b1;
    for (int r = 0; r < 8; r++) begin
      push("score2_view", 8'h02);
      observe(r);
    end
    ui_in[2] = 1'b0;
    do_reset();
    c0 = col(0);
    c1 = col(2);
    c2 = col(4);
    c10 = col(10);
    p = 0;
    for (int i = 7; i >= 0; i--)
      if (i != c0 && i != c1 && i != c2) p = i;
    move(3, p);
    wait_cyc(10 * DP + 8);
    push("two_miss_row7", 8'(1) << p);
    observe(7);
    wait_cyc(12 * DP + 8);
    push("over_row7", 8'hFF);
    observe(7);
    wait_cyc(15 * DP + 8);
    push("frozen_row0", 8'h00);
    observe(0);
    push("frozen_row1", 8'(1) << c10);
    observe(1);
    press(0);
    press(1);
    push("over_nomove", 8'hFF);
    observe(7);
    ui_in[2] = 1'b1;
    push("over_score", 8'h00);
    observe(3);
    ui_in[2] = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
